store_align_unit: RTL and testbench

//  Write-side counterpart of the load-data truncation path. It takes a store request
//  (address, rs2 data, width code), checks alignment, and builds a lane-aligned 64-bit

---
 rtl/store_align_unit_pkg.sv | 34 +++
 rtl/store_align_unit_if.sv | 30 +++
 rtl/store_align_unit_store_buf_fifo.sv | 74 +++++++
 rtl/store_align_unit.sv | 98 +++++++++
 tb/tb_store_align_unit.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/store_align_unit_pkg.sv
// Shared memory-access width codes and byte-lane mask constants for the
// load truncation and store alignment paths.
package store_align_unit_pkg;

    typedef enum logic [2:0] {
        MW_NONE = 3'b000,
        MW_D    = 3'b001,
        MW_W    = 3'b010,
        MW_H    = 3'b011,
        MW_B    = 3'b100,
        MW_WU   = 3'b101,
        MW_HU   = 3'b110,
        MW_BU   = 3'b111
    } mem_width_e;

    localparam logic [7:0] LANE_MASK_D = 8'hFF;
    localparam logic [7:0] LANE_MASK_W = 8'h0F;
    localparam logic [7:0] LANE_MASK_H = 8'h03;
    localparam logic [7:0] LANE_MASK_B = 8'h01;

    // Byte enables for a store of width w at byte offset s within the doubleword.
    function automatic logic [7:0] lane_mask(mem_width_e w, logic [2:0] s);
        logic [7:0] m;
        case (w)
            MW_D:    m = LANE_MASK_D;
            MW_W:    m = LANE_MASK_W << s;
            MW_H:    m = LANE_MASK_H << s;
            MW_B:    m = LANE_MASK_B << s;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_align_unit_if.sv
// Store request (MEM stage) and data-memory write port bundle.
interface store_align_unit_if #(
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_data;
    logic [2:0]        req_width;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [7:0]        mem_wmask;
    logic              misalign;
    logic [ADDR_W-1:0] misalign_addr;
    logic              sb_empty;

    modport master (
        output req_valid, req_addr, req_data, req_width, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wmask,
               misalign, misalign_addr, sb_empty
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_width, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_wmask,
               misalign, misalign_addr, sb_empty
    );
endinterface

// File: rtl/store_align_unit_store_buf_fifo.sv
// Store buffer: DEPTH entries of {addr, wdata, wmask}, head presented combinationally.
module store_buf_fifo #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [63:0]       push_wdata_i,
    input  logic [7:0]        push_wmask_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [63:0]       head_wdata_o,
    output logic [7:0]        head_wmask_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok, pop_ok;

    logic [ADDR_W-1:0] addr_mem  [DEPTH];
    logic [63:0]       wdata_mem [DEPTH];
    logic [7:0]        wmask_mem [DEPTH];

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: the head is gated to zero while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_mem[wr_ptr_q]  <= push_addr_i;
            wdata_mem[wr_ptr_q] <= push_wdata_i;
            wmask_mem[wr_ptr_q] <= push_wmask_i;
        end
    end

    assign head_addr_o  = empty_o ? '0 : addr_mem[rd_ptr_q];
    assign head_wdata_o = empty_o ? '0 : wdata_mem[rd_ptr_q];
    assign head_wmask_o = empty_o ? '0 : wmask_mem[rd_ptr_q];

endmodule

// File: rtl/store_align_unit.sv
// Store alignment check and byte-lane builder feeding a small store buffer
// that drains to the data-memory write port.
module store_align_unit
    import store_align_unit_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 64
) (
    input  logic               clk,
    input  logic               rstn,
    store_align_unit_if.slave  bus
);
    mem_width_e        width;
    logic [2:0]        lane_s;
    logic              width_ok;
    logic              aligned;
    logic              accept;
    logic              push;
    logic [63:0]       lane_wdata;
    logic [7:0]        lane_wmask;
    logic [ADDR_W-1:0] dw_addr;
    logic              full, empty;

    logic              misalign_q, misalign_d;
    logic [ADDR_W-1:0] misalign_addr_q, misalign_addr_d;

    assign width  = mem_width_e'(bus.req_width);
    assign lane_s = bus.req_addr[2:0];

    always_comb begin
        width_ok   = 1'b1;
        aligned    = 1'b1;
        lane_wdata = '0;
        case (width)
            MW_D: begin
                aligned    = (lane_s == 3'b000);
                lane_wdata = bus.req_data;
            end
            MW_W: begin
                aligned    = (lane_s[1:0] == 2'b00);
                lane_wdata = {2{bus.req_data[31:0]}};
            end
            MW_H: begin
                aligned    = !lane_s[0];
                lane_wdata = {4{bus.req_data[15:0]}};
            end
            MW_B: begin
                lane_wdata = {8{bus.req_data[7:0]}};
            end
            default: width_ok = 1'b0;
        endcase
    end

    assign lane_wmask = lane_mask(width, lane_s);
    assign dw_addr    = {bus.req_addr[ADDR_W-1:3], 3'b000};
    assign accept     = bus.req_valid && bus.req_ready;
    assign push       = accept && width_ok && aligned;

    always_comb begin
        misalign_d      = accept && width_ok && !aligned;
        misalign_addr_d = misalign_d ? bus.req_addr : misalign_addr_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    store_buf_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk          (clk),
        .rstn         (rstn),
        .push_i       (push),
        .push_addr_i  (dw_addr),
        .push_wdata_i (lane_wdata),
        .push_wmask_i (lane_wmask),
        .pop_i        (bus.mem_ready),
        .full_o       (full),
        .empty_o      (empty),
        .head_addr_o  (bus.mem_addr),
        .head_wdata_o (bus.mem_wdata),
        .head_wmask_o (bus.mem_wmask)
    );

    assign bus.req_ready     = !full;
    assign bus.mem_valid     = !empty;
    assign bus.sb_empty      = empty;
    assign bus.misalign      = misalign_q;
    assign bus.misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit: lane-build vector table plus
// backpressure, simultaneous push/pop and mid-drain reset sequences.
module tb_store_align_unit;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    store_align_unit_if #(.ADDR_W(64)) bus ();

    store_align_unit #(.DEPTH(2), .ADDR_W(64)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [2:0]  width;
        logic        ev;
        logic [63:0] eaddr;
        logic [63:0] ewdata;
        logic [7:0]  emask;
        logic        emis;
        logic [63:0] emaddr;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%016h required=0x%016h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic v, input logic [63:0] a, input logic [63:0] d, input logic [2:0] w);
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.req_data  = d;
        bus.req_width = w;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{64'h1005, 64'hAB,                  3'b100, 1'b1, 64'h1000, 64'hABAB_ABAB_ABAB_ABAB, 8'h20, 1'b0, 64'h0};
        vecs[1]  = '{64'h2004, 64'h1122_3344,           3'b010, 1'b1, 64'h2000, 64'h1122_3344_1122_3344, 8'hF0, 1'b0, 64'h0};
        vecs[2]  = '{64'h3003, 64'h5555,                3'b011, 1'b0, 64'h0,    64'h0,                   8'h00, 1'b1, 64'h3003};
        vecs[3]  = '{64'h4008, 64'h0123_4567_89AB_CDEF, 3'b001, 1'b1, 64'h4008, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0, 64'h3003};
        vecs[4]  = '{64'h500A, 64'hBEEF,                3'b011, 1'b1, 64'h5008, 64'hBEEF_BEEF_BEEF_BEEF, 8'h0C, 1'b0, 64'h3003};
        vecs[5]  = '{64'h6002, 64'h1234_5678,           3'b010, 1'b0, 64'h0,    64'h0,                   8'h00, 1'b1, 64'h6002};
        vecs[6]  = '{64'h7004, 64'hFFFF_0000_FFFF_0000, 3'b001, 1'b0, 64'h0,    64'h0,                   8'h00, 1'b1, 64'h7004};
        vecs[7]  = '{64'h8000, 64'h1111_2222,           3'b101, 1'b0, 64'h0,    64'h0,                   8'h00, 1'b0, 64'h7004};
        vecs[8]  = '{64'h8001, 64'h3333,                3'b000, 1'b0, 64'h0,    64'h0,                   8'h00, 1'b0, 64'h7004};
        vecs[9]  = '{64'h9007, 64'hFFFF_FFFF_FFFF_FF5A, 3'b100, 1'b1, 64'h9000, 64'h5A5A_5A5A_5A5A_5A5A, 8'h80, 1'b0, 64'h7004};
        vecs[10] = '{64'hA006, 64'hDEAD_BEEF_CAFE_1234, 3'b011, 1'b1, 64'hA000, 64'h1234_1234_1234_1234, 8'hC0, 1'b0, 64'h7004};
        vecs[11] = '{64'hB000, 64'hFFFF_FFFF_8765_4321, 3'b010, 1'b1, 64'hB000, 64'h8765_4321_8765_4321, 8'h0F, 1'b0, 64'h7004};

        drive_req(1'b0, 64'h0, 64'h0, 3'b000);
        bus.mem_ready = 1'b0;

        // Reset state
        #23;
        check("rst_mem_valid", 64'(bus.mem_valid), 64'h0);
        check("rst_sb_empty",  64'(bus.sb_empty),  64'h1);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        check("rst_req_ready",     64'(bus.req_ready),  64'h1);
        check("rst_misalign",      64'(bus.misalign),   64'h0);
        check("rst_misalign_addr", bus.misalign_addr,   64'h0);
        check("rst_mem_addr",      bus.mem_addr,        64'h0);
        check("rst_mem_wdata",     bus.mem_wdata,       64'h0);
        check("rst_mem_wmask",     64'(bus.mem_wmask),  64'h0);
        $display("reset state checked");

        // Vector table: one request, observed the next cycle, drained with mem_ready=1
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive_req(1'b1, vecs[i].addr, vecs[i].data, vecs[i].width);
            tick();
            drive_req(1'b0, 64'h0, 64'h0, 3'b000);
            check($sformatf("v%0d_mem_valid", i),     64'(bus.mem_valid), 64'(vecs[i].ev));
            check($sformatf("v%0d_mem_addr", i),      bus.mem_addr,       vecs[i].eaddr);
            check($sformatf("v%0d_mem_wdata", i),     bus.mem_wdata,      vecs[i].ewdata);
            check($sformatf("v%0d_mem_wmask", i),     64'(bus.mem_wmask), 64'(vecs[i].emask));
            check($sformatf("v%0d_misalign", i),      64'(bus.misalign),  64'(vecs[i].emis));
            check($sformatf("v%0d_misalign_addr", i), bus.misalign_addr,  vecs[i].emaddr);
            check($sformatf("v%0d_req_ready", i),     64'(bus.req_ready), 64'h1);
            tick();
            check($sformatf("v%0d_drained", i),       64'(bus.sb_empty),  64'h1);
            check($sformatf("v%0d_misalign_pulse", i), 64'(bus.misalign), 64'h0);
            $display("vec %0d addr=0x%0h width=%0d done", i, vecs[i].addr, vecs[i].width);
        end

        // Backpressure: fill, hold third, drain in order with push+pop overlap
        @(negedge clk);
        bus.mem_ready = 1'b0;
        drive_req(1'b1, 64'h100, 64'hD1D1_D1D1_D1D1_D1D1, 3'b001);
        @(negedge clk);
        drive_req(1'b1, 64'h108, 64'hD2D2_D2D2_D2D2_D2D2, 3'b001);
        tick();
        check("bp_full_ready",  64'(bus.req_ready), 64'h0);
        check("bp_head1_addr",  bus.mem_addr,       64'h100);
        @(negedge clk);
        drive_req(1'b1, 64'h110, 64'hD3D3_D3D3_D3D3_D3D3, 3'b001);
        tick();
        check("bp_held_ready",  64'(bus.req_ready), 64'h0);
        check("bp_stall_wdata", bus.mem_wdata,      64'hD1D1_D1D1_D1D1_D1D1);
        check("bp_stall_valid", 64'(bus.mem_valid), 64'h1);
        @(negedge clk);
        bus.mem_ready = 1'b1;
        tick();
        check("bp_head2_wdata", bus.mem_wdata,      64'hD2D2_D2D2_D2D2_D2D2);
        check("bp_ready_back",  64'(bus.req_ready), 64'h1);
        tick();
        check("pp_head3_addr",  bus.mem_addr,       64'h110);
        check("pp_head3_wdata", bus.mem_wdata,      64'hD3D3_D3D3_D3D3_D3D3);
        check("pp_not_empty",   64'(bus.sb_empty),  64'h0);
        check("pp_ready",       64'(bus.req_ready), 64'h1);
        @(negedge clk);
        drive_req(1'b0, 64'h0, 64'h0, 3'b000);
        tick();
        check("bp_final_empty", 64'(bus.sb_empty),  64'h1);
        $display("backpressure / push+pop sequence done");

        // Mid-drain asynchronous reset
        @(negedge clk);
        bus.mem_ready = 1'b0;
        drive_req(1'b1, 64'h200, 64'hE1, 3'b100);
        @(negedge clk);
        drive_req(1'b1, 64'h208, 64'hE2, 3'b100);
        @(negedge clk);
        drive_req(1'b0, 64'h0, 64'h0, 3'b000);
        check("ar_pre_valid", 64'(bus.mem_valid), 64'h1);
        check("ar_pre_full",  64'(bus.req_ready), 64'h0);
        #2;
        rstn = 1'b0;
        #1;
        check("ar_mem_valid", 64'(bus.mem_valid), 64'h0);
        check("ar_sb_empty",  64'(bus.sb_empty),  64'h1);
        check("ar_req_ready", 64'(bus.req_ready), 64'h1);
        @(negedge clk);
        rstn = 1'b1;
        bus.mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("ar_no_write_%0d", c), 64'(bus.mem_valid), 64'h0);
        end
        $display("async reset sequence done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
